muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine; responder to the decode stage's muldiv request (start, mul/div select, 2-bit op).
- Sits in EX beside the ALU; result feeds the EX result mux via the MULDIV input.
- The pipeline stalls on busy_o and captures result_o on done_o.

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_EN: divide special cases and zero-operand multiplies finish in one cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            sel_i,
  input  logic [1:0]      op_mul_i,
  input  logic [1:0]      op_div_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     opnd_reg;
  logic                is_div_reg;
  logic [1:0]          op_reg;
  logic                neg_reg;
  logic                special_reg;
  logic [XLEN-1:0]     special_res_reg;
  logic [XLEN-1:0]     result_reg;
  logic                done_reg;
  logic                busy_reg;

  // Accept-edge decode of signedness, magnitudes and special cases
  logic            signed1, signed2, sign1, sign2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, div_ovf, special, neg_next;
  logic [XLEN-1:0] special_res;

  always_comb begin
    signed1  = sel_i ? ~op_div_i[0] : (op_mul_i != 2'b11);
    signed2  = sel_i ? ~op_div_i[0] : ~op_mul_i[1];
    sign1    = signed1 & rs1_i[XLEN-1];
    sign2    = signed2 & rs2_i[XLEN-1];
    abs1     = sign1 ? -rs1_i : rs1_i;
    abs2     = sign2 ? -rs2_i : rs2_i;
    div_zero = (rs2_i == '0);
    div_ovf  = signed1 && (rs1_i == INT_MIN) && (rs2_i == '1);
    special  = sel_i && (div_zero || div_ovf);
    // Remainder follows the dividend's sign; product and quotient follow sign1 ^ sign2
    neg_next = (sel_i && op_div_i[1]) ? sign1 : (sign1 ^ sign2);
    if (op_div_i[1])
      special_res = div_zero ? rs1_i : '0;
    else
      special_res = div_zero ? '1 : INT_MIN;
  end

`ifdef MULDIV_FAST_EN
  logic zero_mul;
  assign zero_mul = !sel_i && ((rs1_i == '0) || (rs2_i == '0));
`endif

  // One iteration step; acc holds {partial, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_part;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next = {mul_sum, acc_reg[XLEN-1:1]};
    div_part = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_ge   = (div_part >= {1'b0, opnd_reg});
    div_diff = div_part[XLEN-1:0] - opnd_reg;
    div_next = div_ge ? {div_diff, acc_reg[XLEN-2:0], 1'b1}
                      : {div_part[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    acc_next = is_div_reg ? div_next : mul_next;
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_raw, final_res;

  always_comb begin
    prod_fix = neg_reg ? -acc_next : acc_next;
    div_raw  = op_reg[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (special_reg)
      final_res = special_res_reg;
    else if (is_div_reg)
      final_res = neg_reg ? -div_raw : div_raw;
    else
      final_res = (op_reg == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      acc_reg         <= '0;
      opnd_reg        <= '0;
      is_div_reg      <= 1'b0;
      op_reg          <= '0;
      neg_reg         <= 1'b0;
      special_reg     <= 1'b0;
      special_res_reg <= '0;
      result_reg      <= '0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i && !flush_i) begin
            is_div_reg      <= sel_i;
            op_reg          <= sel_i ? op_div_i : op_mul_i;
            neg_reg         <= neg_next;
            special_reg     <= special;
            special_res_reg <= special_res;
            opnd_reg        <= sel_i ? abs2 : abs1;
            acc_reg         <= {{XLEN{1'b0}}, (sel_i ? abs1 : abs2)};
            cnt_reg         <= '0;
            busy_reg        <= 1'b1;
`ifdef MULDIV_FAST_EN
            if (special || zero_mul) begin
              state_reg  <= DONE;
              result_reg <= special ? special_res : '0;
              done_reg   <= 1'b1;
            end else begin
              state_reg <= CALC;
            end
`else
            state_reg <= CALC;
`endif
          end
        end
        CALC: begin
          if (flush_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ITER) begin
              state_reg  <= DONE;
              result_reg <= final_res;
              done_reg   <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_reg;
  assign done_o   = done_reg;
  assign result_o = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized traffic
// checked every cycle against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        sel_i;
  logic [1:0]  op_mul_i;
  logic [1:0]  op_div_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

`ifdef MULDIV_FAST_EN
  localparam int SPECIAL_DONE = 1;
`else
  localparam int SPECIAL_DONE = 33;
`endif

  muldiv_unit dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .sel_i    (sel_i),
    .op_mul_i (op_mul_i),
    .op_div_i (op_div_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic sel, input logic [1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int ia, ib, r;
    if (!sel) begin
      sa = (op == 2'b11) ? longint'(a) : longint'($signed(a));
      sb = op[1] ? longint'(b) : longint'($signed(b));
      p  = sa * sb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    ia = a;
    ib = b;
    case (op)
      2'b00:   r = ia / ib;
      2'b01:   r = int'(a / b);
      2'b10:   r = ia % ib;
      default: r = int'(a % b);
    endcase
    return r;
  endfunction

  function automatic logic is_fast(input logic sel, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_EN
    if (sel) return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 32'h0) || (b == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: cycles remaining until done, plus the pending result
  logic        m_busy, m_done;
  logic [31:0] m_result, m_pend;
  int          m_left;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0; m_pend <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start_i && !flush_i) begin
          m_busy <= 1'b1;
          if (is_fast(sel_i, sel_i ? op_div_i : op_mul_i, rs1_i, rs2_i)) begin
            m_left   <= 0;
            m_done   <= 1'b1;
            m_result <= ref_result(sel_i, sel_i ? op_div_i : op_mul_i, rs1_i, rs2_i);
          end else begin
            m_left <= 32;
            m_pend <= ref_result(sel_i, sel_i ? op_div_i : op_mul_i, rs1_i, rs2_i);
          end
        end
      end else if (flush_i || m_left == 0) begin
        m_busy <= 1'b0;
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left   <= 0;
        m_done   <= 1'b1;
        m_result <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en && !reset_i) begin
      check("busy_vs_model", {31'b0, busy_o}, {31'b0, m_busy});
      check("done_vs_model", {31'b0, done_o}, {31'b0, m_done});
      check("result_vs_model", result_o, m_result);
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble operands after accept, then check result and done cycle
  task automatic run_op(input string name, input logic sel, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cycle);
    int   dc, busy_n;
    logic got;
    @(negedge clk_i);
    sel_i = sel; op_mul_i = op; op_div_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
    got = 1'b0; dc = 0; busy_n = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (busy_o) busy_n++;
      if (done_o) begin
        got = 1'b1;
        dc  = k;
      end else begin
        @(negedge clk_i);
      end
    end
    check({name, "_done_seen"}, {31'b0, got}, 32'h1);
    check({name, "_result"}, result_o, exp);
    check({name, "_done_cycle"}, dc, exp_cycle);
    check({name, "_busy_cycles"}, busy_n, exp_cycle);
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    reset_i = 1'b1; start_i = 1'b0; sel_i = 1'b0; op_mul_i = 2'b00; op_div_i = 2'b00;
    rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
    #12;
    check("reset_busy", {31'b0, busy_o}, 32'h0);
    check("reset_done", {31'b0, done_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    cmp_en  = 1'b1;

    run_op("mul_7x6", 1'b0, 2'b00, 32'd7, 32'd6, 32'd42, 33);
    run_op("mulh_m1", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    run_op("mulhu_max", 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2", 1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu_big", 1'b1, 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run_op("remu_big", 1'b1, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h1, 33);
    run_op("divu_by0", 1'b1, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_DONE);
    run_op("div_by0", 1'b1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_DONE);
    run_op("rem_by0", 1'b1, 2'b10, 32'd5, 32'd0, 32'd5, SPECIAL_DONE);
    run_op("div_ovf", 1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_DONE);
    run_op("rem_ovf", 1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPECIAL_DONE);
    run_op("mul_5x5", 1'b0, 2'b00, 32'd5, 32'd5, 32'd25, 33);

    // Flush mid-calculation: back to idle, no done, result keeps 25
    @(negedge clk_i);
    sel_i = 1'b0; op_mul_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    repeat (9) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", {31'b0, busy_o}, 32'h0);
    check("flush_result_kept", result_o, 32'd25);
    repeat (30) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
    check("flush_no_done", n, 0);
    run_op("mul_2x2", 1'b0, 2'b00, 32'd2, 32'd2, 32'd4, 33);

    // start held high through busy: exactly one done for the one accept
    @(negedge clk_i);
    sel_i = 1'b0; op_mul_i = 2'b00; rs1_i = 32'd11; rs2_i = 32'd13; start_i = 1'b1;
    n = 0;
    repeat (34) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
    start_i = 1'b0;
    check("held_start_one_done", n, 1);
    check("held_start_result", result_o, 32'd143);
    repeat (3) @(negedge clk_i);

    // Asynchronous reset between edges during CALC
    @(negedge clk_i);
    sel_i = 1'b0; op_mul_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("async_reset_busy", {31'b0, busy_o}, 32'h0);
    check("async_reset_done", {31'b0, done_o}, 32'h0);
    check("async_reset_result", result_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Randomized traffic, including starts while busy, flushes and operand churn
    repeat (3000) begin
      @(negedge clk_i);
      start_i  = ($urandom_range(0, 3) == 0);
      flush_i  = ($urandom_range(0, 49) == 0);
      sel_i    = $urandom_range(0, 1);
      op_mul_i = $urandom_range(0, 3);
      op_div_i = $urandom_range(0, 3);
      rs1_i    = pick_operand();
      rs2_i    = pick_operand();
    end
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    repeat (40) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
